// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants for the FIFO read-side stream logic:
//               skid-buffer occupancy encoding and FIFO read latency.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;
    localparam logic [1:0] OCC_EMPTY  = 2'd0;
    localparam logic [1:0] OCC_ONE    = 2'd1;
    localparam logic [1:0] OCC_TWO    = 2'd2;
    // Cycles from an accepted r_en until fifo_data_out carries the word
    localparam int         RD_LATENCY = 1;
endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_skid_buf
// Description : Two-entry in-order buffer. Head entry drives dout and holds
//               its last value when the buffer empties.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            occ
);

    logic [1:0]            occ_q,  occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    // Next-state for occupancy and the two entries
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clr) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_d = din;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b11:   head_d = din;
                        2'b10: begin
                            tail_d = din;
                            occ_d  = OCC_TWO;
                        end
                        2'b01:   occ_d = OCC_EMPTY;
                        default: occ_d = OCC_ONE;
                    endcase
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_d = tail_q;
                        occ_d  = OCC_ONE;
                        if (push) begin
                            tail_d = din;
                            occ_d  = OCC_TWO;
                        end
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign dout = head_q;
    assign occ  = occ_q;

    // A push into a full buffer without a pop would lose a word
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clr && (occ_q == OCC_TWO)));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side master for an asynchronous FIFO. Issues r_en,
//               absorbs the 1-cycle read latency into a 2-entry skid buffer
//               and presents words as a valid/ready stream at 1 word/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  busy
);

    // The in_flight tracking below assumes a single-cycle FIFO read
    generate
        if (RD_LATENCY != 1) begin : g_lat_chk
            $error("fifo_stream_reader supports RD_LATENCY == 1 only");
        end
    endgenerate

    logic                 in_flight_q, in_flight_d;
    logic                 discard_q,   discard_d;
    logic [CNT_WIDTH-1:0] rd_count_q,  rd_count_d;
    logic [1:0]           occ;
    logic                 pop;
    logic                 capture;
    logic [2:0]           fill;

    // Handshake, capture and read-issue decisions
    always_comb begin
        pop     = m_valid & m_ready & ~flush;
        capture = in_flight_q & ~flush & ~discard_q;
        // Words that will be held after this edge if no new read is issued
        fill    = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};
        fifo_r_en = rst_n & en & ~flush & ~fifo_empty & (fill < 3'd2);
        in_flight_d = fifo_r_en;
        // Marks a word dropped by flush while in flight
        discard_d   = flush & in_flight_q;
        rd_count_d  = rd_count_q + CNT_WIDTH'(pop);
    end

    // Control flags and delivered-word counter
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            rd_count_q  <= rd_count_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (rclk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (capture),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (m_data),
        .occ   (occ)
    );

    assign m_valid  = (occ != OCC_EMPTY);
    assign busy     = (occ != OCC_EMPTY) | in_flight_q;
    assign rd_count = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed bench with a FIFO model and an expected-word queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rst_n;
    logic          en, flush, m_ready;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_r_en, m_valid, busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_pop = 0;
    int            n_reads = 0;

    always #5 rclk = ~rclk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk          (rclk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_r_en     (fifo_r_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .rd_count      (rd_count),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered empty flag, data one cycle after r_en
    always @(posedge rclk) begin
        if (fifo_r_en) begin
            n_reads++;
            if (fifo_q.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
            else fifo_data_out <= fifo_q.pop_front();
        end
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: every accepted word must be the oldest expected word
    always @(negedge rclk) begin
        if (rst_n && m_valid && m_ready && !flush) begin
            n_pop++;
            if (exp_q.size() == 0) chk("sb_unexpected", {24'd0, m_data}, 32'hFFFF_FFFF);
            else chk("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic step();
        @(posedge rclk); #1;
    endtask

    task automatic preload(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < max_cyc) begin
            step();
            c++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int base_reads;
        int c;
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; m_ready = 1'b1;

        // Reset with a non-empty FIFO and en=1
        preload(8'h10, 8);
        step(); step();
        @(negedge rclk);
        chk("rst_empty_flag", fifo_empty, 0);
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);

        // Streaming at full rate
        step(); rst_n = 1'b1;
        @(negedge rclk); chk("strm_first_ren", fifo_r_en, 1);
        @(negedge rclk); chk("strm_lat_valid0", m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk); chk("strm_valid", m_valid, 1);
        end
        @(negedge rclk);
        chk("strm_end_valid", m_valid, 0);
        chk("strm_count", rd_count, 8);
        chk("strm_ren_off", fifo_r_en, 0);
        chk("strm_sb_empty", exp_q.size(), 0);

        // Backpressure: only two reads may be issued
        step(); m_ready = 1'b0;
        base_reads = n_reads;
        preload(8'h10, 8);
        repeat (8) step();
        chk("bp_reads", n_reads - base_reads, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 8'h10);
        m_ready = 1'b1;
        drain("bp_drain", 40);
        chk("bp_count_wrap", rd_count, CW'(n_pop));
        chk("bp_count_abs", rd_count, 0);

        // en dropped after the third read
        base_reads = n_reads;
        preload(8'h20, 8);
        c = 0;
        while ((n_reads - base_reads) < 3 && c < 20) begin step(); c++; end
        en = 1'b0;
        repeat (6) step();
        chk("en_reads", n_reads - base_reads, 3);
        chk("en_left", exp_q.size(), 5);
        chk("en_idle_valid", m_valid, 0);
        chk("en_idle_busy", busy, 0);
        en = 1'b1;
        drain("en_drain", 40);

        // Flush with two words buffered and nothing in flight
        m_ready = 1'b0;
        preload(8'h30, 8);
        repeat (6) step();
        chk("fl2_valid_pre", m_valid, 1);
        flush = 1'b1;
        @(negedge rclk); chk("fl2_ren_block", fifo_r_en, 0);
        step(); flush = 1'b0;
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        @(negedge rclk);
        chk("fl2_valid_post", m_valid, 0);
        step(); m_ready = 1'b1;
        drain("fl2_drain", 40);

        // Flush mid-stream: head word 0x42 and in-flight 0x43 are dropped
        preload(8'h40, 8);
        c = 0;
        while (!(exp_q.size() != 0 && exp_q[0] == 8'h42 && m_valid) && c < 20) begin step(); c++; end
        chk("fl1_head", m_data, 8'h42);
        chk("fl1_inflight", busy, 1);
        flush = 1'b1;
        step(); flush = 1'b0;
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        @(negedge rclk);
        chk("fl1_valid_post", m_valid, 0);
        drain("fl1_drain", 40);
        chk("fl1_count", rd_count, CW'(n_pop));

        // Asynchronous reset in the middle of a stream
        preload(8'h50, 8);
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_count", rd_count, 0);
        chk("arst_ren", fifo_r_en, 0);
        fifo_q.delete(); exp_q.delete(); n_pop = 0;
        step(); step();
        rst_n = 1'b1;

        // Concurrent writes and random backpressure; 20 words wrap the counter
        begin
            int nw;
            nw = 0; c = 0;
            while ((nw < 20 || exp_q.size() != 0) && c < 400) begin
                step(); c++;
                m_ready = 1'($urandom_range(0, 1));
                wr_en = 1'b0;
                if (nw < 20 && $urandom_range(0, 1) == 1) begin
                    wr_en   = 1'b1;
                    wr_data = DW'(8'h60 + nw);
                    exp_q.push_back(DW'(8'h60 + nw));
                    nw++;
                end
            end
            wr_en = 1'b0; m_ready = 1'b1;
            chk("cc_writes", nw, 20);
            chk("cc_sb_empty", exp_q.size(), 0);
            step(); step();
            chk("cc_count", rd_count, 4);
            chk("cc_popped", n_pop, 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
